// File: rtl/booth_operand_sequencer.sv
// Operand sequencer for a combinational booth multiplier: queues {x, multiplier}
// pairs, presents one at a time for HOLD_CYCLES, then captures the product.
module booth_operand_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_mult,
  output logic [3:0] x,
  output logic [3:0] multiplier,
  input  logic [8:0] mul_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_x,
  output logic [3:0] out_mult,
  output logic [8:0] out_result,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are
  // both high; the producer holds valid and data stable until that edge.

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       mult_q, mult_d;
  logic [3:0]       out_x_q, out_x_d;
  logic [3:0]       out_mult_q, out_mult_d;
  logic [8:0]       out_result_q, out_result_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       mem_q [DEPTH];

  logic push;
  logic pop;

  assign in_ready   = (count_q < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != '0);
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);
  assign state_dbg  = state_q;
  assign x          = x_q;
  assign multiplier = mult_q;
  assign out_x      = out_x_q;
  assign out_mult   = out_mult_q;
  assign out_result = out_result_q;
  assign out_valid  = out_valid_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    x_d          = x_q;
    mult_d       = mult_q;
    out_x_d      = out_x_q;
    out_mult_d   = out_mult_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          x_d     = mem_q[rd_ptr_q][7:4];
          mult_d  = mem_q[rd_ptr_q][3:0];
          hold_d  = HOLD_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          // Operands have been stable long enough for the multiplier to settle.
          out_result_d = mul_result;
          out_x_d      = x_q;
          out_mult_d   = mult_q;
          out_valid_d  = 1'b1;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= 8'd0;
      x_q          <= 4'd0;
      mult_q       <= 4'd0;
      out_x_q      <= 4'd0;
      out_mult_q   <= 4'd0;
      out_result_q <= 9'd0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      x_q          <= x_d;
      mult_q       <= mult_d;
      out_x_q      <= out_x_d;
      out_mult_q   <= out_mult_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Storage needs no reset: count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_mult};
  end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Bench for booth_operand_sequencer: directed latency/stall/reset cases plus
// randomized traffic checked against an in-order queue model of accepted pairs.
module tb_booth_operand_sequencer;

  logic       clk, rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_x, in_mult, x, multiplier, out_x, out_mult;
  logic [8:0] mul_result, out_result;
  logic [1:0] state_dbg;

  logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [3:0] in_x_1, in_mult_1, x_1, multiplier_1, out_x_1, out_mult_1;
  logic [8:0] mul_result_1, out_result_1;
  logic [1:0] state_dbg_1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_emitted = 0;

  logic [7:0] exp_q[$];

  // Ideal multipliers standing in for the booth array.
  assign mul_result   = 9'(x) * 9'(multiplier);
  assign mul_result_1 = 9'(x_1) * 9'(multiplier_1);

  booth_operand_sequencer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mult(in_mult), .x(x), .multiplier(multiplier),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_mult(out_mult), .out_result(out_result),
    .busy(busy), .state_dbg(state_dbg)
  );

  booth_operand_sequencer #(.DEPTH(4), .HOLD_CYCLES(1)) u_dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_x(in_x_1), .in_mult(in_mult_1), .x(x_1), .multiplier(multiplier_1),
    .mul_result(mul_result_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_x(out_x_1), .out_mult(out_mult_1), .out_result(out_result_1),
    .busy(busy_1), .state_dbg(state_dbg_1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic       prev_valid, prev_fire;
  logic [8:0] prev_result;
  logic [3:0] prev_ox, prev_om;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      if (prev_valid && !prev_fire) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, prev_result);
        check("hold_out_x", out_x, prev_ox);
        check("hold_out_mult", out_mult, prev_om);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_emit", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("sb_out_x", out_x, e[7:4]);
          check("sb_out_mult", out_mult, e[3:0]);
          check("sb_result", out_result, 16'(e[7:4]) * 16'(e[3:0]));
          n_emitted++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_x, in_mult});
      prev_valid  = out_valid;
      prev_fire   = out_valid && out_ready;
      prev_result = out_result;
      prev_ox     = out_x;
      prev_om     = out_mult;
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    bit ok;
    ok = 1'b0;
    in_x = a; in_mult = b; in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((busy || out_valid) && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Edges from now until out_valid is first seen high (limit on expiry).
  task automatic wait_valid(input int limit, output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid && k < limit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int base;
    int cnt;
    bit seen_low;
    bit fire;
    logic [8:0] r_hold;
    logic [3:0] x_hold, m_hold;

    rst = 1'b0;
    in_valid = 1'b0; in_x = 4'd0; in_mult = 4'd0; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_x_1 = 4'd0; in_mult_1 = 4'd0; out_ready_1 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_x", x, 0);
    check("rst_mult", multiplier, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_mult", out_mult, 0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_busy", busy, 0);
    @(posedge clk); #1;

    // Single pair, default hold: pop at E0+1, result after E0+9.
    push_pair(4'hC, 4'h5);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        check("pop_x", x, 12);
        check("pop_mult", multiplier, 5);
      end
    end while (!out_valid && k < 40);
    check("latency_e0_9", k, 9);
    check("res_60", out_result, 60);
    check("res_60_x", out_x, 12);
    check("res_60_mult", out_mult, 5);
    wait_idle(40);

    // Back-to-back pairs: first result 8 edges after second push, next 10 later.
    push_pair(4'd9, 4'd8);
    push_pair(4'd15, 4'd15);
    wait_valid(40, k);
    check("b2b_first_lat", k, 8);
    check("res_72", out_result, 72);
    k = 0;
    seen_low = 1'b0;
    do begin
      @(posedge clk); #1;
      k++;
      if (!out_valid) seen_low = 1'b1;
    end while (!(seen_low && out_valid) && k < 40);
    check("b2b_gap", k, 10);
    check("res_225", out_result, 225);
    wait_idle(40);

    // Downstream stalled: one pair in flight, four queued, sixth stalled.
    base = n_emitted;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(4'(i + 1), 4'(i + 10));
    in_x = 4'd7; in_mult = 4'd6; in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    wait_valid(40, k);
    check("stall_valid", out_valid, 1);
    r_hold = out_result; x_hold = x; m_hold = multiplier;
    check("stall_first_res", r_hold, 10);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_result", out_result, r_hold);
      check("stall_x", x, x_hold);
      check("stall_mult", multiplier, m_hold);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fire = 1'b0;
    for (int t = 0; t < 100 && !fire; t++) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sixth_accepted", fire, 1);
    wait_idle(200);
    check("six_emitted", n_emitted - base, 6);

    // Reset during the third WAIT cycle with two pairs queued.
    push_pair(4'd2, 4'd3);
    push_pair(4'd4, 4'd5);
    push_pair(4'd6, 4'd7);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_mult", multiplier, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("no_emit_after_rst", cnt, 0);

    // Minimum hold instance: result after E0+2.
    in_x_1 = 4'd3; in_mult_1 = 4'd7; in_valid_1 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid_1 && k < 20);
    check("hold1_latency", k, 2);
    check("hold1_res_21", out_result_1, 21);
    check("hold1_out_x", out_x_1, 3);
    check("hold1_out_mult", out_mult_1, 7);

    // Randomized traffic with random downstream back-pressure.
    base = n_emitted;
    in_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_x     = 4'($urandom_range(0, 15));
        in_mult  = 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    fire = !in_valid;
    for (int t = 0; t < 200 && !fire; t++) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rand_last_accepted", fire, 1);
    wait_idle(400);
    @(negedge clk);
    check("rand_queue_drained", 16'(exp_q.size()), 0);
    check("rand_some_results", 16'(n_emitted - base > 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_operand_sequencer.md
BOOTH_OPERAND_SEQUENCER -- requirements
Module: booth_operand_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: operand FIFO entries; power of two, 2..16.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 8: cycles operands are held before result sampling; 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-low.
REQ-005 Port in_valid  input  1  upstream operand pair valid.
REQ-006 Port in_ready  output  1  FIFO can accept a pair.
REQ-007 Port in_x  input  4  unsigned multiplicand.
REQ-008 Port in_mult  input  4  unsigned multiplier.
REQ-009 Port x  output  4  multiplicand driven to the booth multiplier.
REQ-010 Port multiplier  output  4  multiplier operand driven to the booth multiplier.
REQ-011 Port mul_result  input  9  product returned by the booth multiplier.
REQ-012 Port out_valid  output  1  captured result available.
REQ-013 Port out_ready  input  1  downstream accepts result.
REQ-014 Port out_x, out_mult  output  4 each  operands belonging to out_result.
REQ-015 Port out_result  output  9  captured product.
REQ-016 Port busy  output  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-017 A push SHALL occur on an edge where in_valid and in_ready are both 1; the FIFO stores {in_x, in_mult} at the write pointer.
REQ-018 in_ready SHALL equal (count < DEPTH) combinationally; when full, a same-cycle pop SHALL NOT enable a push.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be unchanged on a simultaneous push and pop.
REQ-020 The FSM SHALL have states IDLE, WAIT and EMIT.
REQ-021 IDLE with the FIFO non-empty SHALL pop the head into the x/multiplier registers, load hold counter with HOLD_CYCLES-1, and go to WAIT, all on one edge.
REQ-022 In WAIT, if counter != 0 it SHALL decrement; if counter == 0 the block SHALL capture mul_result into out_result, copy x/multiplier into out_x/out_mult, set out_valid, and go to EMIT.
REQ-023 In EMIT, out_valid, out_result, out_x and out_mult SHALL remain stable until out_valid & out_ready on an edge, which clears out_valid and returns to IDLE.
REQ-024 x and multiplier SHALL change only on a pop edge and SHALL hold their last value otherwise.
REQ-025 Latency: a pair pushed at edge E0 into an empty FIFO with the FSM in IDLE SHALL be popped at E0+1 and SHALL have out_valid asserted after edge E0+1+HOLD_CYCLES (E0+9 at default).
REQ-026 Pairs SHALL be processed in strict FIFO order, one at a time; no pop SHALL occur outside IDLE.
REQ-027 Pushes SHALL continue while in WAIT or EMIT, limited only by in_ready.
REQ-028 out_result SHALL be mul_result unmodified (9-bit unsigned); the block performs no arithmetic on it.
REQ-029 The hold counter SHALL be 8 bits wide; no other counter SHALL wrap during normal operation.

Reset
REQ-030 On rst low, the block SHALL immediately clear state to IDLE, pointers, count and counter to 0, and x, multiplier, out_x, out_mult, out_result and out_valid to 0.
REQ-031 Asserting rst mid-WAIT or mid-EMIT SHALL discard the in-flight pair and all FIFO contents; no result SHALL be emitted for them.
REQ-032 After rst returns high, in_ready SHALL be 1 and busy SHALL be 0 on the first cycle.

Verification
REQ-033 Push (in_x=4'hC, in_mult=4'h5), model returns x*multiplier -> x=12, multiplier=5 after E0+1; out_valid after E0+9; out_result=60, out_x=12, out_mult=5.
REQ-034 Push (9,8) then (15,15) back-to-back with out_ready=1 -> out_result=72 followed by 225, in order, no gaps other than one IDLE cycle between them.
REQ-035 Hold out_ready=0 and push 6 pairs -> first pair in EMIT, 4 pairs queued, in_ready=0 with the 6th pair stalled; release out_ready -> all 6 results emitted in order.
REQ-036 Hold out_ready=0 for 20 cycles in EMIT -> out_result and out_valid are stable throughout; x and multiplier are unchanged.
REQ-037 Assert rst at the 3rd WAIT cycle with 2 pairs queued -> outputs zeroed immediately; no out_valid afterward without new pushes; busy=0.
REQ-038 Set HOLD_CYCLES=1, push (3,7) -> out_valid after E0+2, out_result=21.
